// File: rtl/altera_sig_mac_accum_if.sv
// Term/result stream bundle for the MAC accumulator.
// The slave side is the accumulator; the master side is the stage that feeds it
// and also drains its results.
interface altera_sig_mac_accum_if #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 24
);
  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sat;
  logic                    out_trunc;
  logic                    overrun;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_sat, out_trunc, overrun
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_sat, out_trunc, overrun
  );
endinterface

// File: rtl/altera_sig_mac_accum.sv
// Framed sum-of-products accumulator.
// Sums signed terms over a frame, then rounds (half toward +inf), shifts and
// saturates the total into one output word. A single pending slot behind the
// output register lets a second result finish before the input has to stall.
module altera_sig_mac_accum #(
  parameter int IN_W      = 33,
  parameter int ACC_W     = 41,
  parameter int OUT_W     = 24,
  parameter int SHIFT     = 16,
  parameter int MAX_TERMS = 256
) (
  input logic                   clock,
  input logic                   sclr_n,
  altera_sig_mac_accum_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // Rounding constant and output limits, all at the ACC_W+1 working width.
  localparam logic signed [ACC_W:0] RND  = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      QMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      QMIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PEND} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_ovf_neg;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_valid;
  logic                    r_out_sat;
  logic                    r_out_trunc;
  logic [OUT_W-1:0]        r_pnd_data;
  logic                    r_pnd_sat;
  logic                    r_pnd_trunc;
  logic                    r_overrun;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_add_ovf;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_ovf_any;
  logic                    w_ovf_neg;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_cnt_full;
  logic                    w_frame_end;
  logic                    w_trunc;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic [OUT_W-1:0]        w_res_data;
  logic                    w_res_sat;
  logic                    w_slot_free;
  logic                    w_load_out;
  logic                    w_load_pnd;
  logic                    w_from_pnd;

  assign w_in_ready  = (r_state != S_PEND);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_slot_free = ~r_out_valid | bus.out_ready;

  // One extra bit on the add exposes signed overflow of the accumulator.
  assign w_sum      = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
  assign w_add_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_next = w_sum[ACC_W-1:0];
  assign w_ovf_any  = r_ovf | w_add_ovf;
  // Direction of the most recent wrap decides which limit an overflowed frame takes.
  assign w_ovf_neg  = w_add_ovf ? w_sum[ACC_W] : r_ovf_neg;

  assign w_cnt_next  = r_cnt + CNT_W'(1);
  assign w_cnt_full  = (w_cnt_next == CNT_W'(MAX_TERMS));
  assign w_frame_end = w_accept & (bus.in_last | w_cnt_full);
  assign w_trunc     = w_cnt_full & ~bus.in_last;

  assign w_rnd = {w_acc_next[ACC_W-1], w_acc_next} + RND;
  assign w_shr = w_rnd >>> SHIFT;

  // Saturate the shifted total; accumulator overflow overrides to a hard limit.
  always_comb begin
    w_res_data = w_shr[OUT_W-1:0];
    w_res_sat  = 1'b0;
    if (w_ovf_any) begin
      w_res_data = w_ovf_neg ? QMIN : QMAX;
      w_res_sat  = 1'b1;
    end else if (w_shr > OMAX) begin
      w_res_data = QMAX;
      w_res_sat  = 1'b1;
    end else if (w_shr < OMIN) begin
      w_res_data = QMIN;
      w_res_sat  = 1'b1;
    end
  end

  // Next state and routing of a finished result (output register vs pending slot).
  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    w_load_pnd  = 1'b0;
    w_from_pnd  = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_frame_end) begin
          if (w_slot_free) begin
            w_load_out  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_pnd  = 1'b1;
            w_state_nxt = S_PEND;
          end
        end else if (w_accept) begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_PEND: begin
        if (w_slot_free) begin
          w_load_out  = 1'b1;
          w_from_pnd  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!sclr_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Accumulator, term count and overflow tracking; cleared at every frame end.
  always_ff @(posedge clock) begin
    if (!sclr_n || w_frame_end) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ovf_neg <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= w_acc_next;
      r_cnt     <= w_cnt_next;
      r_ovf     <= w_ovf_any;
      r_ovf_neg <= w_ovf_neg;
    end
  end

  // Pending slot holds a result that finished while the output was stalled.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      r_pnd_data  <= '0;
      r_pnd_sat   <= 1'b0;
      r_pnd_trunc <= 1'b0;
    end else if (w_load_pnd) begin
      r_pnd_data  <= w_res_data;
      r_pnd_sat   <= w_res_sat;
      r_pnd_trunc <= w_trunc;
    end
  end

  // Output register: holds steady under backpressure, reloads as it drains.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_trunc <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out_data  <= w_from_pnd ? r_pnd_data  : w_res_data;
      r_out_sat   <= w_from_pnd ? r_pnd_sat   : w_res_sat;
      r_out_trunc <= w_from_pnd ? r_pnd_trunc : w_trunc;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag for beats offered while stalled (those beats are lost).
  always_ff @(posedge clock) begin
    if (!sclr_n)                          r_overrun <= 1'b0;
    else if (bus.in_valid && !w_in_ready) r_overrun <= 1'b1;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_trunc = r_out_trunc;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_altera_sig_mac_accum.sv
// Bench for altera_sig_mac_accum: two instances (default, and SHIFT=8 /
// MAX_TERMS=4) share one stimulus stream; each is compared every cycle with a
// frame-level model built from a true running sum and a two-deep result queue.
module tb_altera_sig_mac_accum;

  logic               clock = 1'b0;
  logic               sclr_n;
  logic signed [32:0] in_data;
  logic               in_valid, in_last, out_ready;

  always #5 clock = ~clock;

  altera_sig_mac_accum_if #(.IN_W(33), .OUT_W(24)) ifa ();
  altera_sig_mac_accum_if #(.IN_W(33), .OUT_W(24)) ifb ();

  assign ifa.in_data = in_data;  assign ifb.in_data = in_data;
  assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
  assign ifa.in_last = in_last;  assign ifb.in_last = in_last;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  altera_sig_mac_accum dut_a (.clock(clock), .sclr_n(sclr_n), .bus(ifa.slave));

  altera_sig_mac_accum #(.IN_W(33), .ACC_W(35), .OUT_W(24), .SHIFT(8), .MAX_TERMS(4))
    dut_b (.clock(clock), .sclr_n(sclr_n), .bus(ifb.slave));

  typedef struct { longint d; bit sat; bit trunc; } res_t;

  int     SH[2] = '{16, 8};
  int     MX[2] = '{256, 4};
  int     AW[2] = '{41, 35};
  res_t   hq[2][2];
  int     hn[2];
  longint macc[2], tsum[2];
  int     mcnt[2];
  bit     movf[2], movr[2];

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Result of a closed frame from the true sum, per the rounding/saturation rules.
  function automatic res_t finish(input int i);
    res_t   r;
    longint omax, omin, v;
    omax = (longint'(1) << 23) - 1;
    omin = -(longint'(1) << 23);
    r.trunc = 1'b0;
    if (movf[i]) begin
      r.d = (tsum[i] < 0) ? omin : omax;
      r.sat = 1'b1;
    end else begin
      v = (macc[i] + (longint'(1) << (SH[i] - 1))) >>> SH[i];
      r.sat = 1'b1;
      if (v > omax)      r.d = omax;
      else if (v < omin) r.d = omin;
      else begin r.d = v; r.sat = 1'b0; end
    end
    return r;
  endfunction

  task automatic model_step(input int i);
    longint lim, nacc;
    bit     pop, fin;
    res_t   r;
    if (!sclr_n) begin
      hn[i] = 0; macc[i] = 0; tsum[i] = 0; mcnt[i] = 0; movf[i] = 0; movr[i] = 0;
      return;
    end
    pop = (hn[i] > 0) && out_ready;
    fin = 1'b0;
    r   = '{0, 1'b0, 1'b0};
    if (in_valid && hn[i] == 2) movr[i] = 1'b1;
    else if (in_valid) begin
      lim  = longint'(1) << (AW[i] - 1);
      nacc = macc[i] + longint'(in_data);
      tsum[i] += longint'(in_data);
      if (nacc >= lim)      begin movf[i] = 1'b1; nacc -= 2 * lim; end
      else if (nacc < -lim) begin movf[i] = 1'b1; nacc += 2 * lim; end
      macc[i] = nacc;
      mcnt[i]++;
      if (in_last || mcnt[i] == MX[i]) begin
        fin = 1'b1;
        r = finish(i);
        r.trunc = !in_last;
        macc[i] = 0; tsum[i] = 0; mcnt[i] = 0; movf[i] = 0;
      end
    end
    if (pop) begin hq[i][0] = hq[i][1]; hn[i]--; end
    if (fin) begin hq[i][hn[i]] = r; hn[i]++; end
  endtask

  task automatic chk_dut(input int i, input logic rdy, input logic vld, input logic signed [23:0] d,
                         input logic sat, input logic tr, input logic ovr);
    string p;
    p = (i == 0) ? "A" : "B";
    chk({p, "_in_ready"}, rdy, hn[i] < 2);
    chk({p, "_out_valid"}, vld, hn[i] > 0);
    chk({p, "_overrun"}, ovr, movr[i]);
    if (hn[i] > 0) begin
      chk({p, "_out_data"}, d, hq[i][0].d);
      chk({p, "_out_sat"}, sat, hq[i][0].sat);
      chk({p, "_out_trunc"}, tr, hq[i][0].trunc);
    end
  endtask

  // One clock: drive, check on the falling edge, advance the model on the rising edge.
  task automatic step(input bit v, input bit l, input logic signed [32:0] d, input bit ordy);
    in_valid = v; in_last = l; in_data = d; out_ready = ordy;
    @(negedge clock);
    if (chk_en) begin
      chk_dut(0, ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_sat, ifa.out_trunc, ifa.overrun);
      chk_dut(1, ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_sat, ifb.out_trunc, ifb.overrun);
    end
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
  endtask

  initial begin
    logic signed [32:0] rd;
    sclr_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_in_ready", ifb.in_ready, 1);
    chk("rst_overrun", ifb.overrun, 0);
    sclr_n = 1'b1;

    // Four-term frame.
    for (int k = 0; k < 3; k++) step(1, 0, 33'sh10000, 1);
    chk("t1_not_yet", ifa.out_valid, 0);
    step(1, 1, 33'sh10000, 1);
    chk("t1_valid", ifa.out_valid, 1);
    chk("t1_data", ifa.out_data, 4);
    chk("t1_sat", ifa.out_sat, 0);
    chk("t1_trunc", ifa.out_trunc, 0);

    // Rounding half toward +inf.
    step(1, 1, 33'sh18000, 1);
    chk("rnd_pos", ifa.out_data, 2);
    step(1, 1, -33'sh18000, 1);
    chk("rnd_neg", ifa.out_data, -1);

    // Saturation on the SHIFT=8 instance.
    step(1, 0, 33'sh080000000, 1);
    step(1, 1, 33'sh080000000, 1);
    chk("sat_pos_data", ifb.out_data, 8388607);
    chk("sat_pos_flag", ifb.out_sat, 1);
    step(1, 0, -33'sh080000000, 1);
    step(1, 1, -33'sh080000000, 1);
    chk("sat_neg_data", ifb.out_data, -8388608);
    chk("sat_neg_flag", ifb.out_sat, 1);

    // Backpressure: output held, second result pending, third beat dropped.
    step(0, 0, 0, 1);
    step(1, 1, 33'sh10000, 0);
    step(1, 1, 33'sh20000, 0);
    chk("bp_in_ready", ifa.in_ready, 0);
    step(1, 1, 33'sh30000, 0);
    chk("bp_overrun", ifa.overrun, 1);
    chk("bp_held", ifa.out_data, 1);
    step(0, 0, 0, 1);
    chk("bp_second", ifa.out_data, 2);
    chk("bp_second_vld", ifa.out_valid, 1);
    chk("bp_ready_back", ifa.in_ready, 1);
    step(0, 0, 0, 1);
    chk("bp_drained", ifa.out_valid, 0);

    // Truncation on the MAX_TERMS=4 instance.
    for (int k = 0; k < 4; k++) step(1, 0, 33'sh10000, 1);
    chk("tr_data", ifb.out_data, 1024);
    chk("tr_flag", ifb.out_trunc, 1);
    step(1, 0, 33'sh10000, 1);
    step(1, 0, 33'sh10000, 1);
    step(1, 1, 33'sh10000, 1);
    chk("tr_next_data", ifb.out_data, 768);
    chk("tr_next_flag", ifb.out_trunc, 0);
    chk("tr_a_data", ifa.out_data, 7);

    // Reset mid-frame.
    step(1, 0, 33'sh10000, 1);
    step(1, 0, 33'sh10000, 1);
    sclr_n = 1'b0;
    step(0, 0, 0, 1);
    chk("mr_overrun", ifa.overrun, 0);
    chk("mr_valid", ifa.out_valid, 0);
    sclr_n = 1'b1;
    step(1, 1, 33'sh10000, 1);
    chk("mr_data", ifa.out_data, 1);
    chk("mr_overrun2", ifa.overrun, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      sclr_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) rd = {$urandom_range(0, 1) == 1, 32'($urandom)};
      else                           rd = 33'($signed(20'($urandom)));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rd, $urandom_range(0, 9) < 6);
    end
    sclr_n = 1'b1;
    step(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/altera_sig_mac_accum.md
Name: altera_sig_mac_accum

Overview:
- Downstream consumer of the two-product sum-of-products stage.
- Accumulates framed 33-bit signed sum-of-products results into a wide accumulator, giving an N-term dot product (FIR tap sum).
- At frame end, rounds, shifts and saturates the sum to an output word, then presents it on a valid/ready output.
- Contains a one-entry pending buffer, so the upstream pipeline is stalled only when two finished results are waiting.

Parameters:
- IN_W, 33, width of the signed input term (matches the upstream result width).
- ACC_W, 41, signed accumulator width (IN_W + log2(MAX_TERMS)).
- OUT_W, 24, signed output width.
- SHIFT, 16, arithmetic right shift applied at frame end (SHIFT >= 1).
- MAX_TERMS, 256, maximum terms per frame; frame is force-closed at this count.

Ports:
- clock  in  1  rising-edge clock.
- sclr_n  in  1  synchronous active-low reset.
- in_data  in  IN_W  signed term from the upstream stage.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  qualifies the final term of a frame (meaningful only with in_valid).
- in_ready  out  1  block can accept a term this cycle.
- out_data  out  OUT_W  signed rounded/saturated frame result.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  1  result was clipped, or the accumulator overflowed; valid with out_valid.
- out_trunc  out  1  frame was force-closed at MAX_TERMS; valid with out_valid.
- overrun  out  1  sticky: a beat arrived while in_ready=0.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low; all state updates on rising clock.
- Reset values (sclr_n=0 at an edge): acc=0, count=0, state=IDLE, pending empty, out_valid=0, out_data=0, out_sat=0, out_trunc=0, overrun=0. Reset mid-frame discards the partial frame and any pending/held result.

Input acceptance:
- A beat is accepted when in_valid & in_ready.
- in_ready=1 in IDLE and ACCUM, 0 in PEND.
- Beats with in_valid & !in_ready are dropped and set overrun (cleared only by reset).

States:
- IDLE: no frame open. An accepted beat loads acc = sext(in_data), count=1 and goes to ACCUM, unless it is last.
- ACCUM: an accepted beat sets acc = acc + sext(in_data) and increments count.
- Accumulator overflow: signed overflow of ACC_W sets an internal ovf flag; acc then wraps, but the final result is forced to the saturation limit matching the sign of the true sum.
- PEND: a finished result sits in the pending buffer. It moves to the output register on the first edge where the output slot is free, then state returns to IDLE.

Frame end:
- A frame ends on an accepted beat with in_last=1, or on the MAX_TERMS-th accepted beat (the latter sets trunc=1).
- A single-beat frame (last on the first beat) is legal; its result is the term alone.
- Final value: F = acc_next + 2^(SHIFT-1), computed at ACC_W+1 bits. Arithmetic shift right by SHIFT (round half toward +inf), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- sat = clipped | ovf.
- Output slot is free when out_valid=0 or out_ready=1 in that cycle. If free, load out_data/out_sat/out_trunc and set out_valid next cycle; state -> IDLE. Otherwise store in pending; state -> PEND.
- acc, count and ovf clear at frame end; a new frame may start on the very next cycle (IDLE) but not while in PEND.

Latency and handshake:
- Latency: the last beat at edge k gives out_valid=1 after edge k (one cycle) when the slot is free.
- out_valid clears after an edge with out_ready=1 unless a new result loads on the same edge. Back-to-back results are allowed: pending transfers on the same edge out_ready drains the output.
- out_data/out_sat/out_trunc stay stable while out_valid & !out_ready.

Test Plan:
- 4-term frame of 0x10000 each, last on 4th, out_ready=1 -> out_data=4, out_sat=0, out_trunc=0, out_valid one cycle after the last beat.
- Rounding: single-beat frames 0x18000 then -0x18000 (SHIFT=16) -> out_data=2, then out_data=-1.
- Saturation: SHIFT=8; two beats 0x0_8000_0000, last on 2nd -> out_data=8388607, out_sat=1; same with negated terms -> -8388608, out_sat=1.
- Backpressure: out_ready=0; two 1-beat frames (0x10000, 0x20000) -> first held on output, second in pending, in_ready=0, a third beat sets overrun=1; raise out_ready -> 1 then 2 on consecutive cycles, in_ready returns to 1.
- Truncation: MAX_TERMS=4; 6 beats of 0x10000, no last -> first result 4 with out_trunc=1; next frame starts at beat 5.
- Reset mid-frame: 2 beats of 0x10000, sclr_n=0 one cycle, then a 1-beat frame 0x10000 last -> out_data=1, overrun=0.
